ad2s1210_read_scheduler: RTL and testbench
==========================================

AD2S1210_READ_SCHEDULER -- requirements
Module: ad2s1210_read_scheduler

Interface
REQ-001 SHALL expose parameter COUNTER_WIDTH, default 32, width of the period timer and period input.
REQ-002 SHALL expose parameter TIMEOUT_WIDTH, default 16, width of the timeout counter and timeout input.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  scheduler run enable.
REQ-006 SHALL have port trigger_mode  in  1  0 = internal period timer, 1 = external_trigger.
REQ-007 SHALL have port external_trigger  in  1  rising-edge start request when trigger_mode=1.
REQ-008 SHALL have port period  in  COUNTER_WIDTH  clock cycles between internal ticks.
REQ-009 SHALL have port speed_ratio  in  8  every Nth read is a speed read; 0 = angle only.
REQ-010 SHALL have port timeout  in  TIMEOUT_WIDTH  max cycles from issue to read_done; 0 = no timeout.
REQ-011 SHALL have port read_done  in  1  single-cycle pulse, reader output beat accepted (valid & ready).
REQ-012 SHALL have port clear_faults  in  1  clears sticky fault flags and overrun_count.
REQ-013 SHALL have port read_angle  out  1  single-cycle angle read start to the CU.
REQ-014 SHALL have port read_speed  out  1  single-cycle speed read start to the CU.
REQ-015 SHALL have port busy  out  1  high from issue until read_done or timeout.
REQ-016 SHALL have port overrun  out  1  sticky, a tick arrived while busy.
REQ-017 SHALL have port overrun_count  out  16  saturating count of dropped ticks.
REQ-018 SHALL have port timeout_fault  out  1  sticky, a read exceeded timeout.

Function
REQ-019 SHALL implement states IDLE, WAIT_TICK, ISSUE, WAIT_DONE.
REQ-020 IDLE -> WAIT_TICK when enable=1; timer and read index held at 0 in IDLE.
REQ-021 Internal tick: timer counts 0..P-1, tick asserted in the cycle timer==P-1, timer wraps to 0; P = max(period,2).
REQ-022 External tick: asserted one cycle after a 0->1 transition of the registered external_trigger; timer frozen at 0 while trigger_mode=1.
REQ-023 Timer SHALL run continuously in WAIT_TICK, ISSUE and WAIT_DONE (fixed cadence, independent of read latency).
REQ-024 WAIT_TICK -> ISSUE on tick; ISSUE lasts exactly one cycle, then WAIT_DONE; latency tick -> read pulse = 1 cycle.
REQ-025 In ISSUE exactly one of read_angle/read_speed SHALL be high; never both, never outside ISSUE.
REQ-026 Read index k counts 0..speed_ratio-1, advanced once per ISSUE, wraps to 0; read_speed when speed_ratio!=0 and k==speed_ratio-1, else read_angle.
REQ-027 speed_ratio=1 SHALL yield speed reads only; change of speed_ratio resets k to 0.
REQ-028 WAIT_DONE -> WAIT_TICK on read_done; tick in the same cycle as read_done -> ISSUE next cycle, not an overrun.
REQ-029 Tick while in ISSUE, or in WAIT_DONE without read_done, SHALL be dropped, set overrun, increment overrun_count saturating at 0xFFFF.
REQ-030 Timeout counter cleared on ISSUE, incremented in WAIT_DONE; reaching timeout (nonzero) sets timeout_fault and returns to WAIT_TICK; read_done in that same cycle wins (no fault).
REQ-031 busy SHALL be high in ISSUE and WAIT_DONE, low otherwise.
REQ-032 enable deassert in WAIT_TICK -> IDLE next cycle; in ISSUE/WAIT_DONE the in-flight read completes (done or timeout), then IDLE; no new issue while enable=0.
REQ-033 clear_faults clears overrun, overrun_count, timeout_fault; a fault event in the same cycle wins (flag set, count = 1).
REQ-034 read_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-035 reset=0 at a clock edge SHALL force IDLE, timer=0, k=0, timeout counter=0.
REQ-036 During and after reset read_angle=0, read_speed=0, busy=0, overrun=0, overrun_count=0, timeout_fault=0.
REQ-037 Reset mid-read SHALL abandon the read; a later read_done SHALL be ignored.

Verification
REQ-038 period=100, speed_ratio=4, read_done 10 cycles after each pulse -> pulses every 100 cycles, pattern A,A,A,S repeating, overrun=0.
REQ-039 period=20, read_done 30 cycles after pulse -> every other tick dropped, overrun=1, overrun_count increments per dropped tick.
REQ-040 timeout=50, no read_done -> timeout_fault=1 at cycle 50 after pulse, busy falls same edge, next tick issues a read.
REQ-041 trigger_mode=1, three external_trigger edges -> three pulses, each 2 cycles after the edge; held-high trigger gives one pulse.
REQ-042 enable dropped 5 cycles after a pulse, read_done at 10 -> no further pulses, busy low after done, state IDLE.
REQ-043 reset asserted in WAIT_DONE, read_done 3 cycles after release -> all outputs 0, no state change from the stray done.

Source files
------------

// File: rtl/ad2s1210_read_scheduler.sv
`default_nettype none
// ============================================================================
// ad2s1210_read_scheduler : timed/triggered angle+speed read sequencer
// Revision 1.0
// ============================================================================
module ad2s1210_read_scheduler #(
  parameter int COUNTER_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trigger_mode,
  input  logic                     external_trigger,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic [7:0]               speed_ratio,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     read_done,
  input  logic                     clear_faults,
  output logic                     read_angle,
  output logic                     read_speed,
  output logic                     busy,
  output logic                     overrun,
  output logic [15:0]              overrun_count,
  output logic                     timeout_fault
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_TICK = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] timer_q, timer_d;
  logic [COUNTER_WIDTH-1:0] period_eff, timer_last;
  logic [TIMEOUT_WIDTH-1:0] to_q, to_d;
  logic [7:0]               k_q, k_d, sr_q, k_eff;
  logic                     ext_q, ext_prev_q;
  logic                     overrun_q, overrun_d;
  logic                     tof_q, tof_d;
  logic [15:0]              ovc_q, ovc_d;
  logic                     running, tick, to_hit, drop, speed_slot;

  assign period_eff = (period < COUNTER_WIDTH'(2)) ? COUNTER_WIDTH'(2) : period;
  assign timer_last = period_eff - COUNTER_WIDTH'(1);
  assign running    = (state_q != S_IDLE);
  assign tick       = running && (trigger_mode ? (ext_q && !ext_prev_q)
                                               : (timer_q >= timer_last));
  assign to_hit     = (state_q == S_WAIT_DONE) && (timeout != '0) &&
                      (to_q == timeout - TIMEOUT_WIDTH'(1));
  assign drop       = tick && ((state_q == S_ISSUE) ||
                               ((state_q == S_WAIT_DONE) && !read_done));
  // a new ratio restarts the angle/speed pattern from its first slot
  assign k_eff      = (speed_ratio != sr_q) ? 8'd0 : k_q;
  assign speed_slot = (speed_ratio != 8'd0) && (k_eff == speed_ratio - 8'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      to_q       <= '0;
      k_q        <= 8'd0;
      sr_q       <= 8'd0;
      ext_q      <= 1'b0;
      ext_prev_q <= 1'b0;
      overrun_q  <= 1'b0;
      ovc_q      <= 16'd0;
      tof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      to_q       <= to_d;
      k_q        <= k_d;
      sr_q       <= speed_ratio;
      ext_q      <= external_trigger;
      ext_prev_q <= ext_q;
      overrun_q  <= overrun_d;
      ovc_q      <= ovc_d;
      tof_q      <= tof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_ISSUE;
      end
      S_ISSUE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (read_done || to_hit) begin
          if (!enable)                 state_d = S_IDLE;
          else if (read_done && tick)  state_d = S_ISSUE;
          else                         state_d = S_WAIT_TICK;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d = '0;
    if (running && (state_d != S_IDLE) && !trigger_mode && (timer_q < timer_last))
      timer_d = timer_q + COUNTER_WIDTH'(1);

    to_d = '0;
    if (state_q == S_WAIT_DONE)
      to_d = to_q + TIMEOUT_WIDTH'(1);

    k_d = k_eff;
    if (state_q == S_ISSUE)
      k_d = ((k_eff + 8'd1) >= speed_ratio) ? 8'd0 : (k_eff + 8'd1);
    if (state_d == S_IDLE)
      k_d = 8'd0;

    // a fault event outranks a simultaneous clear
    overrun_d = overrun_q;
    ovc_d     = ovc_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (clear_faults)          ovc_d = 16'd1;
      else if (ovc_q != 16'hFFFF) ovc_d = ovc_q + 16'd1;
    end else if (clear_faults) begin
      overrun_d = 1'b0;
      ovc_d     = 16'd0;
    end

    tof_d = tof_q;
    if (to_hit && !read_done) tof_d = 1'b1;
    else if (clear_faults)    tof_d = 1'b0;
  end

  always_comb begin
    read_angle = 1'b0;
    read_speed = 1'b0;
    busy       = 1'b0;
    if (state_q == S_ISSUE) begin
      busy       = 1'b1;
      read_speed = speed_slot;
      read_angle = !speed_slot;
    end else if (state_q == S_WAIT_DONE) begin
      busy = 1'b1;
    end
  end

  assign overrun       = overrun_q;
  assign overrun_count = ovc_q;
  assign timeout_fault = tof_q;

endmodule
`default_nettype wire

// File: tb/tb_ad2s1210_read_scheduler.sv
`default_nettype none
// tb_ad2s1210_read_scheduler : directed scenarios plus randomized rounds against a cycle model
module tb_ad2s1210_read_scheduler;

  logic        clock = 1'b0;
  logic        reset, enable, trigger_mode, external_trigger, read_done, clear_faults;
  logic [31:0] period;
  logic [7:0]  speed_ratio;
  logic [15:0] timeout;
  logic        read_angle, read_speed, busy, overrun, timeout_fault;
  logic [15:0] overrun_count;

  ad2s1210_read_scheduler #(.COUNTER_WIDTH(32), .TIMEOUT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .trigger_mode(trigger_mode),
    .external_trigger(external_trigger), .period(period), .speed_ratio(speed_ratio),
    .timeout(timeout), .read_done(read_done), .clear_faults(clear_faults),
    .read_angle(read_angle), .read_speed(read_speed), .busy(busy), .overrun(overrun),
    .overrun_count(overrun_count), .timeout_fault(timeout_fault)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  // model: m_run = scheduler active, m_busy = read outstanding, m_issue = pulse cycle
  bit m_run, m_busy, m_issue, m_ovr, m_flt, m_e1, m_e2;
  int m_age, m_n, m_k, m_cnt, m_sr_prev;
  int done_delay;
  bit stray_done, force_done;
  int n_pulses, n_speed, last_pulse, last_gap, e_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int ke, sr, p;
    bit tk, done, hit, nrun, nbusy, nissue, e_spd;
    sr = int'(speed_ratio);
    read_done = force_done ||
                (done_delay >= 0 && m_busy && !m_issue && m_age == done_delay) ||
                (stray_done && $urandom_range(0, 15) == 0);
    ke    = (sr != m_sr_prev) ? 0 : m_k;
    e_spd = m_issue && sr != 0 && ke == sr - 1;
    @(negedge clock);
    chk("read_angle", 32'(read_angle), 32'(m_issue && !e_spd));
    chk("read_speed", 32'(read_speed), 32'(e_spd));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("overrun_count", 32'(overrun_count), 32'(m_cnt));
    chk("timeout_fault", 32'(timeout_fault), 32'(m_flt));
    if (read_angle || read_speed) begin
      n_pulses++;
      if (read_speed) n_speed++;
      last_gap   = cyc - last_pulse;
      last_pulse = cyc;
    end
    @(posedge clock);
    if (!reset) begin
      m_run = 0; m_busy = 0; m_issue = 0; m_ovr = 0; m_flt = 0; m_e1 = 0; m_e2 = 0;
      m_age = 0; m_n = 0; m_k = 0; m_cnt = 0; m_sr_prev = 0;
    end else begin
      p    = (period < 2) ? 2 : int'(period);
      tk   = m_run && (trigger_mode ? (m_e1 && !m_e2) : (m_n % p == p - 1));
      done = m_busy && !m_issue && read_done;
      hit  = m_busy && !m_issue && !done && timeout != 0 && m_age == int'(timeout);
      if (tk && m_busy && !done) begin
        m_ovr = 1;
        m_cnt = clear_faults ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
      end else if (clear_faults) begin
        m_ovr = 0;
        m_cnt = 0;
      end
      if (hit) m_flt = 1;
      else if (clear_faults) m_flt = 0;
      if (!m_run) begin
        nrun = enable; nissue = 0; nbusy = 0;
      end else if (m_issue || (m_busy && !(done || hit))) begin
        nrun = 1; nissue = 0; nbusy = 1;
      end else begin
        nrun = enable; nissue = enable && (!m_busy || done) && tk; nbusy = nissue;
      end
      m_k = m_issue ? ((sr == 0) ? 0 : (ke + 1) % sr) : ke;
      if (!nrun) m_k = 0;
      m_age = nissue ? 0 : (nbusy ? m_age + 1 : 0);
      m_n   = (nrun && m_run) ? m_n + 1 : 0;
      m_run = nrun; m_busy = nbusy; m_issue = nissue;
      m_sr_prev = sr;
      m_e2 = m_e1;
      m_e1 = external_trigger;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic restart();
    reset = 0; enable = 0; clear_faults = 0; external_trigger = 0; force_done = 0;
    run(2);
    reset = 1;
    n_pulses = 0; n_speed = 0; last_pulse = cyc; last_gap = 0;
  endtask

  task automatic wait_pulse(input string tag);
    int t = 0;
    while (!m_issue && t < 1000) begin step(); t++; end
    chk(tag, 32'(read_angle || read_speed), 32'd1);
  endtask

  initial begin
    reset = 0; enable = 0; trigger_mode = 0; external_trigger = 0; read_done = 0;
    clear_faults = 0; period = 100; speed_ratio = 4; timeout = 0;
    done_delay = -1; stray_done = 0; force_done = 0;
    repeat (2) @(posedge clock);
    #1;
    enable = 1;
    run(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(overrun_count), 32'd0);

    // steady 100-cycle cadence, A,A,A,S
    restart(); period = 100; speed_ratio = 4; done_delay = 10; enable = 1;
    run(420);
    chk("s1_pulses", 32'(n_pulses), 32'd4);
    chk("s1_speed", 32'(n_speed), 32'd1);
    chk("s1_gap", 32'(last_gap), 32'd100);
    chk("s1_overrun", 32'(overrun), 32'd0);

    // reads slower than the tick rate: every other tick dropped
    restart(); period = 20; speed_ratio = 0; done_delay = 30; enable = 1;
    run(205);
    chk("s2_pulses", 32'(n_pulses), 32'd5);
    chk("s2_gap", 32'(last_gap), 32'd40);
    chk("s2_overrun", 32'(overrun), 32'd1);
    chk("s2_count", 32'(overrun_count), 32'd5);
    clear_faults = 1; step(); clear_faults = 0;
    chk("s2_cleared", 32'(overrun_count), 32'd0);

    // timeout with no completion
    restart(); period = 100; speed_ratio = 4; timeout = 50; done_delay = -1; enable = 1;
    run(160);
    chk("s3_fault", 32'(timeout_fault), 32'd1);
    chk("s3_busy", 32'(busy), 32'd0);
    run(50);
    chk("s3_pulses", 32'(n_pulses), 32'd2);

    // external trigger: three edges plus one held-high level
    restart(); trigger_mode = 1; timeout = 0; speed_ratio = 2; done_delay = 3; enable = 1;
    run(3);
    for (int i = 0; i < 3; i++) begin
      e_cyc = cyc;
      external_trigger = 1; step(); external_trigger = 0;
      run(10);
      chk("s4_latency", 32'(last_pulse - e_cyc), 32'd2);
    end
    external_trigger = 1; run(30); external_trigger = 0; run(5);
    chk("s4_pulses", 32'(n_pulses), 32'd4);
    chk("s4_speed", 32'(n_speed), 32'd2);

    // enable dropped while a read is in flight
    restart(); trigger_mode = 0; period = 100; speed_ratio = 0; done_delay = 10; enable = 1;
    wait_pulse("s5_first");
    run(5); enable = 0; run(300);
    chk("s5_pulses", 32'(n_pulses), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);

    // reset mid-read, then a stray completion
    restart(); done_delay = -1; enable = 1;
    wait_pulse("s6_first");
    run(5); reset = 0; enable = 0; run(2); reset = 1; run(3);
    force_done = 1; step(); force_done = 0; run(20);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_pulses", 32'(n_pulses), 32'd1);
    chk("s6_fault", 32'(timeout_fault), 32'd0);

    // randomized rounds; mode and period only change while idle
    for (int r = 0; r < 20; r++) begin
      int t;
      enable = 0; clear_faults = 0; external_trigger = 0;
      t = 0;
      while (m_run && t < 100) begin step(); t++; end
      chk("r_idle", 32'(busy), 32'd0);
      trigger_mode = 1'($urandom_range(0, 1));
      period       = $urandom_range(0, 12);
      speed_ratio  = 8'($urandom_range(0, 5));
      timeout      = 16'($urandom_range(0, 25));
      done_delay   = $urandom_range(1, 20);
      stray_done   = 1'($urandom_range(0, 1));
      enable       = 1;
      for (int i = 0; i < 150; i++) begin
        external_trigger = ($urandom_range(0, 3) == 0);
        clear_faults     = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 59) == 0) speed_ratio = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 79) == 0) enable = ~enable;
        step();
      end
    end
    stray_done = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
